// File: rtl/vram_pkg.sv
// Shared constants and types for the VRAM arbiter slice.
//   FB_W/FB_H   : framebuffer size in source pixels (4x upscaled to 800x600)
//   ADDR_W      : RAM word address width
//   RGB_W       : RAM word / colour width, {r[3:0],g[3:0],b[3:0]}
//   PIX_BLANK   : pixel coordinate value that marks blanking
//   FB_WORDS    : number of valid framebuffer words
//   wr_req_t    : one queued game write {addr, data}
package vram_pkg;

    localparam int unsigned FB_W      = 200;
    localparam int unsigned FB_H      = 150;
    localparam int unsigned ADDR_W    = 15;
    localparam int unsigned RGB_W     = 12;
    localparam logic [9:0]  PIX_BLANK = 10'h3FF;
    localparam int unsigned FB_WORDS  = FB_W * FB_H;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [RGB_W-1:0]  data;
    } wr_req_t;

endpackage

// File: rtl/vram_wr_fifo.sv
// Small synchronous FIFO holding pending game writes.
//   clk, reset_n : clock, asynchronous active-low reset (flushes contents)
//   push, push_data : enqueue request (ignored when full)
//   pop          : dequeue head (ignored when empty)
//   head         : current head entry (valid when !empty)
//   full, empty  : occupancy flags
// DEPTH must be a power of two, at least 2.
module vram_wr_fifo
    import vram_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic    clk,
    input  logic    reset_n,
    input  logic    push,
    input  wr_req_t push_data,
    input  logic    pop,
    output wr_req_t head,
    output logic    full,
    output logic    empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    wr_req_t        mem_q [DEPTH];
    logic [PTR_W:0] wr_ptr_q;
    logic [PTR_W:0] rd_ptr_q;
    logic           do_push;
    logic           do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q[PTR_W-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (PTR_W + 1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (PTR_W + 1)'(1);
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/vram_arbiter.sv
// Shares one single-port synchronous VRAM between display scan-out and game writes.
//   clk, reset_n       : pixel clock, asynchronous active-low reset
//   pixel_x, pixel_y   : display coordinate (10'h3FF = blanking)
//   pix_rgb            : colour for the coordinate presented two cycles earlier
//   wr_valid/wr_ready  : write request handshake, wr_addr/wr_data payload
//   wr_oob             : sticky flag, an accepted write addressed past the framebuffer
//   mem_en/mem_we/mem_addr/mem_wdata : registered RAM command, mem_rdata one cycle later
// Every fourth active pixel (x[1:0]==0) owns the RAM for a read; all other cycles
// drain the write queue. ADDR_W/RGB_W must match the vram_pkg values used by wr_req_t.
module vram_arbiter #(
    parameter int unsigned FB_W     = vram_pkg::FB_W,
    parameter int unsigned FB_H     = vram_pkg::FB_H,
    parameter int unsigned ADDR_W   = vram_pkg::ADDR_W,
    parameter int unsigned RGB_W    = vram_pkg::RGB_W,
    parameter int unsigned WQ_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [9:0]        pixel_x,
    input  logic [9:0]        pixel_y,
    output logic [RGB_W-1:0]  pix_rgb,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [RGB_W-1:0]  wr_data,
    output logic              wr_oob,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [RGB_W-1:0]  mem_wdata,
    input  logic [RGB_W-1:0]  mem_rdata
);

    import vram_pkg::*;

    localparam int unsigned WORDS = FB_W * FB_H;

    logic              active;
    logic              slot;
    logic [ADDR_W-1:0] slot_addr;
    logic              ready_q;
    logic              oob_q;
    logic              accept;
    logic              have_req;
    logic              push_fifo;
    logic              pop_fifo;
    logic              fifo_full;
    logic              fifo_empty;
    wr_req_t           in_req;
    wr_req_t           head_req;
    wr_req_t           issue_req;

    logic              mem_en_d, mem_en_q;
    logic              mem_we_d, mem_we_q;
    logic [ADDR_W-1:0] mem_addr_d, mem_addr_q;
    logic [RGB_W-1:0]  mem_wdata_d, mem_wdata_q;

    logic              slot_q1, slot_q2;
    logic              blank_q1, blank_q2;
    logic [RGB_W-1:0]  hold_q;

    assign active    = (pixel_x != PIX_BLANK) && (pixel_y != PIX_BLANK);
    assign slot      = active && (pixel_x[1:0] == 2'b00);
    assign slot_addr = ADDR_W'(pixel_y[9:2]) * ADDR_W'(FB_W) + ADDR_W'(pixel_x[9:2]);

    // wr_ready stays low until the first clock after reset release.
    assign wr_ready  = ready_q && !fifo_full;
    assign accept    = wr_valid && wr_ready;
    assign in_req    = '{addr: wr_addr, data: wr_data};
    assign wr_oob    = oob_q;

    always_comb begin
        // An incoming write may bypass an empty queue so an idle write issues next cycle.
        have_req    = !fifo_empty || accept;
        issue_req   = fifo_empty ? in_req : head_req;
        pop_fifo    = !slot && !fifo_empty;
        push_fifo   = accept && (slot || !fifo_empty);

        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (slot) begin
            mem_en_d   = 1'b1;
            mem_addr_d = slot_addr;
        end else if (have_req && (32'(issue_req.addr) < WORDS)) begin
            // Out-of-range entries are still dequeued, just never driven to RAM.
            mem_en_d    = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = issue_req.addr;
            mem_wdata_d = issue_req.data;
        end
    end

    vram_wr_fifo #(
        .DEPTH (WQ_DEPTH)
    ) u_wr_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push_fifo),
        .push_data (in_req),
        .pop       (pop_fifo),
        .head      (head_req),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_q     <= 1'b0;
            oob_q       <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            slot_q1     <= 1'b0;
            slot_q2     <= 1'b0;
            blank_q1    <= 1'b1;
            blank_q2    <= 1'b1;
            hold_q      <= '0;
        end else begin
            ready_q     <= 1'b1;
            if (accept && (32'(wr_addr) >= WORDS)) oob_q <= 1'b1;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            slot_q1     <= slot;
            slot_q2     <= slot_q1;
            blank_q1    <= !active;
            blank_q2    <= blank_q1;
            if (slot_q2) hold_q <= mem_rdata;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // Colour select is fully registered; on a slot the RAM's own output register
    // supplies the word directly so it lands in the same cycle as its coordinate.
    always_comb begin
        if (blank_q2)     pix_rgb = '0;
        else if (slot_q2) pix_rgb = mem_rdata;
        else              pix_rgb = hold_q;
    end

endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;

    localparam logic [9:0] BLANK = 10'h3FF;

    logic        clk;
    logic        reset_n;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic [11:0] pix_rgb;
    logic        wr_valid;
    logic        wr_ready;
    logic [14:0] wr_addr;
    logic [11:0] wr_data;
    logic        wr_oob;
    logic        mem_en;
    logic        mem_we;
    logic [14:0] mem_addr;
    logic [11:0] mem_wdata;
    logic [11:0] mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    // RAM: unwritten words read back as their own address (low 12 bits).
    logic [11:0] ram [0:32767];
    bit          written [0:32767];

    // Reference model state.
    logic [9:0]  hx1, hy1, hx2, hy2;
    logic [11:0] model_hold;
    logic [11:0] exp_pix;
    logic [26:0] exp_wq [$];
    int          occ_neg;
    logic        rdy_neg;
    logic        last_acc;

    vram_arbiter u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .pixel_x   (pixel_x),
        .pixel_y   (pixel_y),
        .pix_rgb   (pix_rgb),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_oob    (wr_oob),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr]     <= mem_wdata;
                written[mem_addr] <= 1'b1;
            end else begin
                mem_rdata <= written[mem_addr] ? ram[mem_addr] : mem_addr[11:0];
            end
        end
    end

    function automatic logic [11:0] fb_val(input int a);
        return written[a] ? ram[a] : 12'(a);
    endfunction

    function automatic int fb_addr(input logic [9:0] x, input logic [9:0] y);
        return (int'(y) / 4) * 200 + int'(x) / 4;
    endfunction

    function automatic bit is_slot(input logic [9:0] x, input logic [9:0] y);
        return (x != BLANK) && (y != BLANK) && (int'(x) % 4 == 0);
    endfunction

    // Apply one cycle of stimulus; returns #1 after the next rising edge, when
    // mem_* reflect (hx1,hy1) and pix_rgb reflects (hx2,hy2).
    task automatic drive(input logic [9:0] x, input logic [9:0] y, input logic wv,
                         input logic [14:0] wa, input logic [11:0] wd);
        pixel_x  = x;
        pixel_y  = y;
        wr_valid = wv;
        wr_addr  = wa;
        wr_data  = wd;
        @(negedge clk);
        occ_neg  = exp_wq.size();
        rdy_neg  = wr_ready;
        last_acc = wv && wr_ready;
        if (last_acc && int'(wa) < 30000) exp_wq.push_back({wa, wd});
        @(posedge clk);
        #1;
        hx2 = hx1;
        hy2 = hy1;
        hx1 = x;
        hy1 = y;
        if (hx2 == BLANK || hy2 == BLANK) begin
            exp_pix = '0;
        end else begin
            if (int'(hx2) % 4 == 0) model_hold = fb_val(fb_addr(hx2, hy2));
            exp_pix = model_hold;
        end
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        pixel_x  = BLANK;
        pixel_y  = BLANK;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        hx1 = BLANK; hy1 = BLANK; hx2 = BLANK; hy2 = BLANK;
        model_hold = '0;
        exp_pix    = '0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({pix_rgb, wr_ready, wr_oob, mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got pix=%h rdy=%b oob=%b en=%b we=%b addr=%h wd=%h exp all 0",
                     pix_rgb, wr_ready, wr_oob, mem_en, mem_we, mem_addr, mem_wdata);
        end
        reset_n = 1'b1;
        #1;
        n_tests++;
        if (wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready_before_clk got=%b exp=0", wr_ready);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready_after_clk got=%b exp=1", wr_ready);
        end
    endtask

    task automatic test_scan_line();
        int reads;
        int j;
        logic [11:0] exp;
        reads = 0;
        for (int i = 0; i < 12; i++) begin
            if (i < 8) drive(10'(i), 10'd0, 1'b0, '0, '0);
            else       drive(BLANK, BLANK, 1'b0, '0, '0);
            if (mem_en === 1'b1) reads++;
            n_tests++;
            if (i < 8 && i % 4 == 0) begin
                if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 15'(i / 4)) begin
                    n_fail++;
                    $display("FAIL scan_read i=%0d got en=%b we=%b addr=%0d exp read addr %0d",
                             i, mem_en, mem_we, mem_addr, i / 4);
                end
            end else if (mem_en !== 1'b0) begin
                n_fail++;
                $display("FAIL scan_idle i=%0d got en=%b exp=0", i, mem_en);
            end
            j   = i - 1;
            exp = (j >= 0 && j < 8) ? 12'(j / 4) : 12'h000;
            n_tests++;
            if (pix_rgb !== exp) begin
                n_fail++;
                $display("FAIL scan_pix coord=%0d got=%h exp=%h", j, pix_rgb, exp);
            end
        end
        n_tests++;
        if (reads != 2) begin
            n_fail++;
            $display("FAIL scan_read_count got=%0d exp=2", reads);
        end
    endtask

    task automatic test_corner();
        logic [11:0] exp;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) drive(10'(796 + i), 10'd599, 1'b0, '0, '0);
            else       drive(BLANK, BLANK, 1'b0, '0, '0);
            if (i == 0) begin
                n_tests++;
                if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 15'd29999) begin
                    n_fail++;
                    $display("FAIL corner_addr got en=%b we=%b addr=%0d exp read 29999",
                             mem_en, mem_we, mem_addr);
                end
            end
            if (i >= 1) begin
                exp = (i <= 4) ? 12'h52F : 12'h000;
                n_tests++;
                if (pix_rgb !== exp) begin
                    n_fail++;
                    $display("FAIL corner_pix i=%0d got=%h exp=%h", i, pix_rgb, exp);
                end
            end
        end
    endtask

    task automatic test_random_scan();
        for (int s = 0; s < 50; s++) begin
            logic [9:0] y;
            int x0;
            int len;
            int gap;
            y   = ($urandom_range(0, 9) == 0) ? BLANK : 10'($urandom_range(0, 599));
            x0  = $urandom_range(0, 799);
            len = $urandom_range(1, 24);
            gap = $urandom_range(0, 3);
            for (int i = 0; i < len + gap; i++) begin
                if (i < len && x0 + i < 800) drive(10'(x0 + i), y, 1'b0, '0, '0);
                else                         drive(BLANK, BLANK, 1'b0, '0, '0);
                n_tests++;
                if (is_slot(hx1, hy1)) begin
                    if (mem_en !== 1'b1 || mem_we !== 1'b0 ||
                        mem_addr !== 15'(fb_addr(hx1, hy1))) begin
                        n_fail++;
                        $display("FAIL rscan_read x=%0d y=%0d got en=%b we=%b addr=%0d exp %0d",
                                 hx1, hy1, mem_en, mem_we, mem_addr, fb_addr(hx1, hy1));
                    end
                end else if (mem_en !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rscan_idle x=%0d y=%0d got en=%b exp=0", hx1, hy1, mem_en);
                end
                n_tests++;
                if (pix_rgb !== exp_pix) begin
                    n_fail++;
                    $display("FAIL rscan_pix x=%0d y=%0d got=%h exp=%h", hx2, hy2, pix_rgb, exp_pix);
                end
            end
        end
    endtask

    task automatic test_write_latency();
        drive(BLANK, BLANK, 1'b1, 15'd7, 12'h111);
        n_tests++;
        if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 15'd7 || mem_wdata !== 12'h111) begin
            n_fail++;
            $display("FAIL lat_idle got en=%b we=%b addr=%0d wd=%h exp write 7=111",
                     mem_en, mem_we, mem_addr, mem_wdata);
        end
        drive(10'd0, 10'd40, 1'b1, 15'd9, 12'h222);
        n_tests++;
        if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 15'd2000) begin
            n_fail++;
            $display("FAIL lat_slot got en=%b we=%b addr=%0d exp read 2000", mem_en, mem_we, mem_addr);
        end
        drive(BLANK, BLANK, 1'b0, '0, '0);
        n_tests++;
        if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 15'd9 || mem_wdata !== 12'h222) begin
            n_fail++;
            $display("FAIL lat_delayed got en=%b we=%b addr=%0d wd=%h exp write 9=222",
                     mem_en, mem_we, mem_addr, mem_wdata);
        end
        exp_wq.delete();
    endtask

    task automatic test_write_then_read();
        for (int i = 0; i < 11; i++) begin
            if (i < 8) drive(10'(16 + i), 10'd0, (i == 3), 15'd5, 12'hABC);
            else       drive(BLANK, BLANK, 1'b0, '0, '0);
            if (i == 3) begin
                n_tests++;
                if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 15'd5 ||
                    mem_wdata !== 12'hABC) begin
                    n_fail++;
                    $display("FAIL wtr_write got en=%b we=%b addr=%0d wd=%h exp write 5=ABC",
                             mem_en, mem_we, mem_addr, mem_wdata);
                end
            end
            if (i == 4) begin
                n_tests++;
                if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 15'd5) begin
                    n_fail++;
                    $display("FAIL wtr_read got en=%b we=%b addr=%0d exp read 5", mem_en, mem_we, mem_addr);
                end
            end
            if (i >= 5 && i <= 8) begin
                n_tests++;
                if (pix_rgb !== 12'hABC) begin
                    n_fail++;
                    $display("FAIL wtr_pix x=%0d got=%h exp=abc", 15 + i, pix_rgb);
                end
            end
        end
        exp_wq.delete();
    endtask

    task automatic test_fill();
        int k;
        logic [26:0] e;
        k = 0;
        for (int i = 0; i < 20; i++) begin
            if (i < 6) drive(10'(4 * i), 10'd8, (k < 6), 15'(1000 + k), 12'(k + 1));
            else       drive(BLANK, BLANK, (k < 6), 15'(1000 + k), 12'(k + 1));
            if (last_acc) k++;
            if (mem_en === 1'b1 && mem_we === 1'b1) begin
                n_tests++;
                if (is_slot(hx1, hy1)) begin
                    n_fail++;
                    $display("FAIL fill_write_in_slot addr=%0d exp no write", mem_addr);
                end else if (exp_wq.size() == 0) begin
                    n_fail++;
                    $display("FAIL fill_extra_write got addr=%0d exp none", mem_addr);
                end else begin
                    e = exp_wq.pop_front();
                    if ({mem_addr, mem_wdata} !== e) begin
                        n_fail++;
                        $display("FAIL fill_order got %0d=%h exp %0d=%h",
                                 mem_addr, mem_wdata, e[26:12], e[11:0]);
                    end
                end
            end
            if (i == 5) begin
                n_tests++;
                if (wr_ready !== 1'b0 || k != 4) begin
                    n_fail++;
                    $display("FAIL fill_full got rdy=%b accepted=%0d exp rdy=0 accepted=4", wr_ready, k);
                end
            end
        end
        n_tests++;
        if (k != 6 || exp_wq.size() != 0) begin
            n_fail++;
            $display("FAIL fill_done got accepted=%0d pending=%0d exp 6 and 0", k, exp_wq.size());
        end
    endtask

    task automatic test_burst();
        logic [9:0]  y;
        logic [26:0] e;
        bit          saw_full;
        y = 10'($urandom_range(0, 599));
        saw_full = 0;
        for (int i = 0; i < 140; i++) begin
            if (i < 120) drive(10'(i), y, ($urandom_range(0, 9) != 0),
                               15'($urandom_range(0, 29999)), 12'($urandom));
            else         drive(BLANK, BLANK, 1'b0, '0, '0);
            if (!rdy_neg) saw_full = 1;
            n_tests++;
            if (rdy_neg !== (occ_neg < 4)) begin
                n_fail++;
                $display("FAIL burst_ready i=%0d got=%b exp=%b", i, rdy_neg, (occ_neg < 4));
            end
            n_tests++;
            if (is_slot(hx1, hy1)) begin
                if (mem_en !== 1'b1 || mem_we !== 1'b0 ||
                    mem_addr !== 15'(fb_addr(hx1, hy1))) begin
                    n_fail++;
                    $display("FAIL burst_read i=%0d got en=%b we=%b addr=%0d exp read %0d",
                             i, mem_en, mem_we, mem_addr, fb_addr(hx1, hy1));
                end
            end else if (mem_en === 1'b1 && mem_we !== 1'b1) begin
                n_fail++;
                $display("FAIL burst_stray_read i=%0d addr=%0d exp none", i, mem_addr);
            end else if (mem_en === 1'b1) begin
                if (exp_wq.size() == 0) begin
                    n_fail++;
                    $display("FAIL burst_extra_write i=%0d got addr=%0d exp none", i, mem_addr);
                end else begin
                    e = exp_wq.pop_front();
                    if ({mem_addr, mem_wdata} !== e) begin
                        n_fail++;
                        $display("FAIL burst_order i=%0d got %0d=%h exp %0d=%h",
                                 i, mem_addr, mem_wdata, e[26:12], e[11:0]);
                    end
                end
            end
            n_tests++;
            if (pix_rgb !== exp_pix) begin
                n_fail++;
                $display("FAIL burst_pix i=%0d got=%h exp=%h", i, pix_rgb, exp_pix);
            end
        end
        n_tests++;
        if (!saw_full || exp_wq.size() != 0) begin
            n_fail++;
            $display("FAIL burst_done got saw_full=%0d pending=%0d exp 1 and 0",
                     saw_full, exp_wq.size());
        end
    endtask

    task automatic test_oob();
        n_tests++;
        if (wr_oob !== 1'b0) begin
            n_fail++;
            $display("FAIL oob_initial got=%b exp=0", wr_oob);
        end
        drive(BLANK, BLANK, 1'b1, 15'd30000, 12'hFFF);
        n_tests++;
        if (wr_oob !== 1'b1 || mem_en !== 1'b0) begin
            n_fail++;
            $display("FAIL oob_drop got oob=%b en=%b exp oob=1 en=0", wr_oob, mem_en);
        end
        drive(BLANK, BLANK, 1'b1, 15'd123, 12'h5A5);
        n_tests++;
        if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 15'd123 || mem_wdata !== 12'h5A5) begin
            n_fail++;
            $display("FAIL oob_next_write got en=%b we=%b addr=%0d wd=%h exp write 123=5a5",
                     mem_en, mem_we, mem_addr, mem_wdata);
        end
        drive(BLANK, BLANK, 1'b0, '0, '0);
        n_tests++;
        if (wr_oob !== 1'b1) begin
            n_fail++;
            $display("FAIL oob_sticky got=%b exp=1", wr_oob);
        end
        exp_wq.delete();
    endtask

    task automatic test_reset_flush();
        for (int i = 0; i < 3; i++) drive(10'(4 * i), 10'd0, 1'b1, 15'(2000 + i), 12'h777);
        wr_valid = 1'b0;
        pixel_x  = BLANK;
        pixel_y  = BLANK;
        #2;
        reset_n = 1'b0;
        #1;
        n_tests++;
        if ({pix_rgb, wr_ready, wr_oob, mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin
            n_fail++;
            $display("FAIL flush_async got pix=%h rdy=%b oob=%b en=%b we=%b addr=%h wd=%h exp all 0",
                     pix_rgb, wr_ready, wr_oob, mem_en, mem_we, mem_addr, mem_wdata);
        end
        exp_wq.delete();
        model_hold = '0;
        hx1 = BLANK; hy1 = BLANK; hx2 = BLANK; hy2 = BLANK;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(BLANK, BLANK, 1'b0, '0, '0);
            n_tests++;
            if (mem_en !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_no_write i=%0d got en=%b addr=%0d exp en=0", i, mem_en, mem_addr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan_line();
        test_corner();
        test_random_scan();
        test_write_latency();
        test_write_then_read();
        test_fill();
        test_burst();
        test_oob();
        test_reset_flush();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
